norm_shift_ctrl: RTL and testbench
==================================

Name: norm_shift_ctrl

Overview:
- Leading-zero detection and normalization-shift control for the FPU add/subtract datapath.
- Sits between the significand adder/subtractor output and the normalization barrel shifter.
- Consumes the raw SWR-bit add/sub result, which includes the carry/overflow position at the MSB.
- Produces the shift amount, shift direction and shifted-in bit, all registered, that drive the barrel shifter's Shift_Value_i, Left_Right_i and Bit_Shift_i.
- 2-stage pipeline with valid tracking, so it can accept a new result every cycle.

Parameters:
- SWR, 26: significand width = implicit bit + fraction + guard + round; the add/sub result width. Use 55 for double precision.
- EWR, 8: width of the shift-value output. Constraint: SWR-1 < 2**EWR.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-low; clears all state immediately.
- load_i  input  1  Data_i is valid this cycle; capture it into stage 1.
- Data_i  input  SWR  add/sub result. Bit SWR-1 is the carry/overflow bit; bits SWR-2:0 are the significand (bit SWR-2 is the normalized implicit-bit position).
- Shift_Value_o  output  EWR  normalization shift amount.
- Left_Right_o  output  1  shift direction: 1 = left, 0 = right.
- Bit_Shift_o  output  1  bit shifted into vacated positions; always 0 for normalization.
- Zero_flag_o  output  1  result significand is exactly zero.
- valid_o  output  1  one-cycle pulse; the outputs above carry a new result this cycle.

Behaviour:
- Reset (rst=0, asynchronous) clears all pipeline registers and outputs to 0, including the valid bits. Deassertion takes effect on the next rising edge.
- Latency:
  - Data_i sampled on the edge where load_i=1 reaches the outputs two edges later.
  - valid_o is high for exactly one cycle per load.
  - Throughput is 1 per cycle; there is no back-pressure.
- Stage 1, enabled by load_i:
  - Register the overflow bit (Data_i[SWR-1]).
  - Split Data_i[SWR-2:0] into 4-bit groups, MSB-aligned. Zero-pad the LSB end up to a multiple of 4.
  - Per group, register an all-zero flag and a 2-bit leading-zero count.
  - Register v1 <= load_i every cycle. When load_i=0, v1 <= 0 and the stage-1 data registers hold.
- Stage 2, enabled by v1; register the outputs only when v1=1:
  - Overflow bit = 1: Left_Right_o=0, Shift_Value_o=1, Zero_flag_o=0.
  - Otherwise, if any group is non-zero: LZC = 4*(index of first non-zero group from MSB) + that group's count. Set Left_Right_o=1, Shift_Value_o=LZC, Zero_flag_o=0. LZC ranges 0..SWR-2.
  - All groups zero and overflow bit = 0: Zero_flag_o=1, Shift_Value_o=0, Left_Right_o=1.
  - Bit_Shift_o is always registered as 0.
  - valid_o <= v1 every cycle.
- Hold: when v1=0, all data outputs keep their last value and only valid_o drops.
- Padding bits never contribute to LZC. They can only be reached when the whole significand is zero, and that case is covered by the zero rule.
- Priority: the overflow rule beats the LZC rule. For example, Data_i=all ones gives a right shift by 1.
- Reset mid-flight: any loaded item not yet presented is discarded, and valid_o does not pulse for it.
- LZC is computed at full internal width and zero-extended to EWR bits.

Test Plan (SWR=26, EWR=8):
1. Overflow: load Data_i=26'h2000000 → 2 cycles later valid_o=1, Left_Right_o=0, Shift_Value_o=1, Zero_flag_o=0, Bit_Shift_o=0.
2. Already normalized: Data_i=26'h1000000 → Left_Right_o=1, Shift_Value_o=0, Zero_flag_o=0.
3. Deepest shift and zero:
   - Data_i=26'h0000001 → Left_Right_o=1, Shift_Value_o=24.
   - Then Data_i=0 → Zero_flag_o=1, Shift_Value_o=0, Left_Right_o=1.
4. Back-to-back: loads on 3 consecutive cycles of 26'h0800000, 26'h0000100, 26'h3FFFFFF → valid_o high 3 consecutive cycles with (Shift_Value_o, Left_Right_o) = (1,1), (16,1), (1,0).
5. Hold: after one result, keep load_i=0 for 10 cycles → valid_o stays 0 and Shift_Value_o / Left_Right_o / Zero_flag_o are unchanged.
6. Reset mid-flight: load 26'h0000010, drive rst=0 asynchronously between edges one cycle later → all outputs 0 immediately. After release, valid_o never pulses for the dropped item; a fresh load behaves as in scenario 1.

Source files
------------

// File: rtl/norm_shift_ctrl_if.sv
// Bundle between the add/sub result producer and the normalization control.
// The master drives the add/sub result. The slave returns the barrel-shifter
// control word and a one-cycle valid strobe.
interface norm_shift_ctrl_if #(
  parameter int SWR = 26,
  parameter int EWR = 8
);
  logic           load_i;
  logic [SWR-1:0] Data_i;
  logic [EWR-1:0] Shift_Value_o;
  logic           Left_Right_o;
  logic           Bit_Shift_o;
  logic           Zero_flag_o;
  logic           valid_o;

  modport master (
    output load_i,
    output Data_i,
    input  Shift_Value_o,
    input  Left_Right_o,
    input  Bit_Shift_o,
    input  Zero_flag_o,
    input  valid_o
  );

  modport slave (
    input  load_i,
    input  Data_i,
    output Shift_Value_o,
    output Left_Right_o,
    output Bit_Shift_o,
    output Zero_flag_o,
    output valid_o
  );
endinterface

// File: rtl/norm_shift_ctrl.sv
// Leading-zero detection and normalization-shift control for the FPU add/sub
// datapath. Stage 1 splits the significand into 4-bit groups. For each group
// it registers an all-zero flag and a 2-bit leading-zero count. Stage 2 picks
// the first non-zero group from the MSB and forms the shift control. An
// overflow (carry) bit always forces a right shift by one.
module norm_shift_ctrl #(
  parameter int SWR = 26,
  parameter int EWR = 8
) (
  input logic            clk,
  input logic            rst,
  norm_shift_ctrl_if.slave bus
);

  // Significand width (carry bit excluded), group count, padded width, and
  // the width needed to hold a leading-zero count over the padded vector.
  localparam int SIGW = SWR - 1;
  localparam int NG   = (SIGW + 3) / 4;
  localparam int PADW = 4 * NG;
  localparam int LW   = $clog2(PADW + 1);

  // Stage-1 combinational signals.
  logic [PADW-1:0] sig_pad;
  logic [3:0]      nib;
  logic [NG-1:0]   grp_zero_d;
  logic [1:0]      grp_cnt_d [NG];

  // Stage-1 registers.
  logic            v1_q;
  logic            ovf_q;
  logic [NG-1:0]   grp_zero_q;
  logic [1:0]      grp_cnt_q [NG];

  // Stage-2 combinational signals.
  logic [LW-1:0]   lzc;
  logic            any_nz;

  // Output registers.
  logic [EWR-1:0]  shift_value_q;
  logic            left_right_q;
  logic            bit_shift_q;
  logic            zero_flag_q;
  logic            valid_q;

  // MSB-align the significand. The LSB padding is zero, so it can only be
  // reached when the whole significand is zero.
  always_comb begin
    sig_pad = '0;
    sig_pad[PADW-1 -: SIGW] = bus.Data_i[SWR-2:0];
  end

  // Per-group all-zero flag and 2-bit leading-zero count.
  // Group 0 is the most significant group.
  always_comb begin
    nib        = '0;
    grp_zero_d = '0;
    for (int unsigned g = 0; g < NG; g++) begin
      nib           = sig_pad[PADW-1-4*g -: 4];
      grp_zero_d[g] = (nib == 4'b0000);
      if (nib[3])      grp_cnt_d[g] = 2'd0;
      else if (nib[2]) grp_cnt_d[g] = 2'd1;
      else if (nib[1]) grp_cnt_d[g] = 2'd2;
      else             grp_cnt_d[g] = 2'd3;
    end
  end

  // Stage 1 capture. The valid bit tracks load every cycle, while the data
  // registers update only on a load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1_q       <= 1'b0;
      ovf_q      <= 1'b0;
      grp_zero_q <= '0;
      for (int unsigned g = 0; g < NG; g++) grp_cnt_q[g] <= '0;
    end else begin
      v1_q <= bus.load_i;
      if (bus.load_i) begin
        ovf_q      <= bus.Data_i[SWR-1];
        grp_zero_q <= grp_zero_d;
        for (int unsigned g = 0; g < NG; g++) grp_cnt_q[g] <= grp_cnt_d[g];
      end
    end
  end

  // Priority scan from the MSB group. The first non-zero group gives
  // 4*index + its local count.
  always_comb begin
    lzc    = '0;
    any_nz = 1'b0;
    for (int unsigned g = 0; g < NG; g++) begin
      if (!any_nz && !grp_zero_q[g]) begin
        any_nz = 1'b1;
        lzc    = LW'(4 * g) + LW'(grp_cnt_q[g]);
      end
    end
  end

  // Stage 2 output registers. The data outputs hold when stage 1 is empty,
  // and valid follows the stage-1 valid bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_value_q <= '0;
      left_right_q  <= 1'b0;
      bit_shift_q   <= 1'b0;
      zero_flag_q   <= 1'b0;
      valid_q       <= 1'b0;
    end else begin
      valid_q <= v1_q;
      if (v1_q) begin
        bit_shift_q <= 1'b0;
        if (ovf_q) begin
          left_right_q  <= 1'b0;
          shift_value_q <= EWR'(1);
          zero_flag_q   <= 1'b0;
        end else if (any_nz) begin
          left_right_q  <= 1'b1;
          shift_value_q <= EWR'(lzc);
          zero_flag_q   <= 1'b0;
        end else begin
          left_right_q  <= 1'b1;
          shift_value_q <= '0;
          zero_flag_q   <= 1'b1;
        end
      end
    end
  end

  assign bus.Shift_Value_o = shift_value_q;
  assign bus.Left_Right_o  = left_right_q;
  assign bus.Bit_Shift_o   = bit_shift_q;
  assign bus.Zero_flag_o   = zero_flag_q;
  assign bus.valid_o       = valid_q;

endmodule

// File: tb/tb_norm_shift_ctrl.sv
// Self-checking bench for norm_shift_ctrl. Each load pushes its expected
// result to a queue, tagged with the cycle it should appear on. A negedge
// monitor collects every valid result, and each scenario task compares the
// two queues.
module tb_norm_shift_ctrl;

  localparam int SWR = 26;
  localparam int EWR = 8;

  typedef struct packed {
    logic [EWR-1:0] sv;
    logic           lr;
    logic           zf;
    logic           bs;
    logic [31:0]    cyc;
  } res_t;

  logic        clk;
  logic        rst;
  logic [31:0] cyc;
  int          tests;
  int          fails;
  res_t        exp_q[$];
  res_t        obs_q[$];

  norm_shift_ctrl_if #(.SWR(SWR), .EWR(EWR)) bus ();

  norm_shift_ctrl #(.SWR(SWR), .EWR(EWR)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 32'd1;

  // Monitor: capture every valid result with the cycle it appeared on.
  always @(negedge clk) begin
    if (bus.valid_o === 1'b1)
      obs_q.push_back('{sv: bus.Shift_Value_o, lr: bus.Left_Right_o,
                        zf: bus.Zero_flag_o, bs: bus.Bit_Shift_o, cyc: cyc});
  end

  // Reference model: a bit-by-bit scan, independent of the group structure.
  function automatic res_t model(input logic [SWR-1:0] d, input logic [31:0] c);
    res_t r;
    bit   found;
    r.bs  = 1'b0;
    r.cyc = c;
    r.sv  = '0;
    found = 1'b0;
    if (d[SWR-1]) begin
      r.sv = EWR'(1);
      r.lr = 1'b0;
      r.zf = 1'b0;
    end else begin
      for (int i = SWR - 2; i >= 0; i--) begin
        if (!found && d[i]) begin
          found = 1'b1;
          r.sv  = EWR'(SWR - 2 - i);
        end
      end
      r.lr = 1'b1;
      r.zf = !found;
    end
    return r;
  endfunction

  // Drive one load on the next negedge and record its expected result,
  // which must appear two edges later.
  task automatic load_item(input logic [SWR-1:0] d);
    @(negedge clk);
    bus.load_i = 1'b1;
    bus.Data_i = d;
    exp_q.push_back(model(d, cyc + 32'd2));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.load_i = 1'b0;
    end
  endtask

  // Wait a bounded number of cycles for the outstanding results, then
  // allow a short settle time so that any extra pulses are also seen.
  task automatic wait_drain();
    int n;
    n = 0;
    while (obs_q.size() < exp_q.size() && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    repeat (3) @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst        = 1'b0;
    bus.load_i = 1'b0;
    bus.Data_i = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests++;
      if ({bus.valid_o, bus.Shift_Value_o, bus.Left_Right_o, bus.Zero_flag_o, bus.Bit_Shift_o} !== '0) begin
        fails++;
        $display("FAIL reset_state: valid=%b sv=%0d lr=%b zf=%b bs=%b, need all 0",
                 bus.valid_o, bus.Shift_Value_o, bus.Left_Right_o, bus.Zero_flag_o, bus.Bit_Shift_o);
      end
    end
    rst = 1'b1;
    idle(2);
  endtask

  task automatic test_overflow();
    res_t e, o;
    load_item(26'h2000000);
    idle(1);
    wait_drain();
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      tests++;
      if (o !== e) begin
        fails++;
        $display("FAIL overflow: got sv=%0d lr=%b zf=%b bs=%b cyc=%0d, need sv=%0d lr=%b zf=%b bs=%b cyc=%0d",
                 o.sv, o.lr, o.zf, o.bs, o.cyc, e.sv, e.lr, e.zf, e.bs, e.cyc);
      end
    end
    tests++;
    if (exp_q.size() != 0 || obs_q.size() != 0) begin
      fails++;
      $display("FAIL overflow_count: %0d results unmatched, %0d expected missing", obs_q.size(), exp_q.size());
      exp_q.delete();
      obs_q.delete();
    end
  endtask

  task automatic test_normalized();
    res_t e, o;
    load_item(26'h1000000);
    idle(1);
    wait_drain();
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      tests++;
      if (o !== e) begin
        fails++;
        $display("FAIL normalized: got sv=%0d lr=%b zf=%b bs=%b cyc=%0d, need sv=%0d lr=%b zf=%b bs=%b cyc=%0d",
                 o.sv, o.lr, o.zf, o.bs, o.cyc, e.sv, e.lr, e.zf, e.bs, e.cyc);
      end
    end
    tests++;
    if (exp_q.size() != 0 || obs_q.size() != 0) begin
      fails++;
      $display("FAIL normalized_count: %0d results unmatched, %0d expected missing", obs_q.size(), exp_q.size());
      exp_q.delete();
      obs_q.delete();
    end
  endtask

  task automatic test_deep_and_zero();
    res_t e, o;
    load_item(26'h0000001);
    idle(2);
    load_item(26'h0000000);
    idle(1);
    wait_drain();
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      tests++;
      if (o !== e) begin
        fails++;
        $display("FAIL deep_zero: got sv=%0d lr=%b zf=%b bs=%b cyc=%0d, need sv=%0d lr=%b zf=%b bs=%b cyc=%0d",
                 o.sv, o.lr, o.zf, o.bs, o.cyc, e.sv, e.lr, e.zf, e.bs, e.cyc);
      end
    end
    tests++;
    if (exp_q.size() != 0 || obs_q.size() != 0) begin
      fails++;
      $display("FAIL deep_zero_count: %0d results unmatched, %0d expected missing", obs_q.size(), exp_q.size());
      exp_q.delete();
      obs_q.delete();
    end
  endtask

  task automatic test_back_to_back();
    res_t e, o;
    load_item(26'h0800000);
    load_item(26'h0000100);
    load_item(26'h3FFFFFF);
    idle(1);
    wait_drain();
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      tests++;
      if (o !== e) begin
        fails++;
        $display("FAIL back_to_back: got sv=%0d lr=%b zf=%b bs=%b cyc=%0d, need sv=%0d lr=%b zf=%b bs=%b cyc=%0d",
                 o.sv, o.lr, o.zf, o.bs, o.cyc, e.sv, e.lr, e.zf, e.bs, e.cyc);
      end
    end
    tests++;
    if (exp_q.size() != 0 || obs_q.size() != 0) begin
      fails++;
      $display("FAIL back_to_back_count: %0d results unmatched, %0d expected missing", obs_q.size(), exp_q.size());
      exp_q.delete();
      obs_q.delete();
    end
  endtask

  task automatic test_hold();
    res_t e, o, last;
    load_item(26'h0000100);
    last = exp_q[0];
    idle(1);
    wait_drain();
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      tests++;
      if (o !== e) begin
        fails++;
        $display("FAIL hold_load: got sv=%0d lr=%b zf=%b bs=%b cyc=%0d, need sv=%0d lr=%b zf=%b bs=%b cyc=%0d",
                 o.sv, o.lr, o.zf, o.bs, o.cyc, e.sv, e.lr, e.zf, e.bs, e.cyc);
      end
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      tests++;
      if (bus.valid_o !== 1'b0 || bus.Shift_Value_o !== last.sv ||
          bus.Left_Right_o !== last.lr || bus.Zero_flag_o !== last.zf) begin
        fails++;
        $display("FAIL hold_cycle%0d: got valid=%b sv=%0d lr=%b zf=%b, need valid=0 sv=%0d lr=%b zf=%b",
                 i, bus.valid_o, bus.Shift_Value_o, bus.Left_Right_o, bus.Zero_flag_o,
                 last.sv, last.lr, last.zf);
      end
    end
    #1;
    tests++;
    if (exp_q.size() != 0 || obs_q.size() != 0) begin
      fails++;
      $display("FAIL hold_count: %0d results unmatched, %0d expected missing", obs_q.size(), exp_q.size());
      exp_q.delete();
      obs_q.delete();
    end
  endtask

  task automatic test_reset_midflight();
    res_t e, o;
    // This item is dropped by the reset, so nothing is expected for it.
    @(negedge clk);
    bus.load_i = 1'b1;
    bus.Data_i = 26'h0000010;
    @(posedge clk);
    #2;
    bus.load_i = 1'b0;
    rst        = 1'b0;
    #1;
    tests++;
    if ({bus.valid_o, bus.Shift_Value_o, bus.Left_Right_o, bus.Zero_flag_o, bus.Bit_Shift_o} !== '0) begin
      fails++;
      $display("FAIL midflight_async: valid=%b sv=%0d lr=%b zf=%b bs=%b, need all 0",
               bus.valid_o, bus.Shift_Value_o, bus.Left_Right_o, bus.Zero_flag_o, bus.Bit_Shift_o);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (6) @(negedge clk);
    #1;
    tests++;
    if (obs_q.size() != 0) begin
      fails++;
      $display("FAIL midflight_drop: got %0d results, need 0", obs_q.size());
      obs_q.delete();
    end
    load_item(26'h2000000);
    idle(1);
    wait_drain();
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      tests++;
      if (o !== e) begin
        fails++;
        $display("FAIL midflight_fresh: got sv=%0d lr=%b zf=%b bs=%b cyc=%0d, need sv=%0d lr=%b zf=%b bs=%b cyc=%0d",
                 o.sv, o.lr, o.zf, o.bs, o.cyc, e.sv, e.lr, e.zf, e.bs, e.cyc);
      end
    end
    tests++;
    if (exp_q.size() != 0 || obs_q.size() != 0) begin
      fails++;
      $display("FAIL midflight_count: %0d results unmatched, %0d expected missing", obs_q.size(), exp_q.size());
      exp_q.delete();
      obs_q.delete();
    end
  endtask

  task automatic test_random();
    res_t e, o;
    logic [SWR-1:0] d, msk;
    int unsigned k;
    for (int n = 0; n < 60; n++) begin
      k = $urandom_range(0, SWR);
      if (k == SWR) begin
        d = '0;
      end else begin
        msk = (SWR'(1) << k) - SWR'(1);
        d   = (SWR'(1) << k) | (SWR'($urandom) & msk);
      end
      load_item(d);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
    end
    idle(1);
    wait_drain();
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      tests++;
      if (o !== e) begin
        fails++;
        $display("FAIL random: got sv=%0d lr=%b zf=%b bs=%b cyc=%0d, need sv=%0d lr=%b zf=%b bs=%b cyc=%0d",
                 o.sv, o.lr, o.zf, o.bs, o.cyc, e.sv, e.lr, e.zf, e.bs, e.cyc);
      end
    end
    tests++;
    if (exp_q.size() != 0 || obs_q.size() != 0) begin
      fails++;
      $display("FAIL random_count: %0d results unmatched, %0d expected missing", obs_q.size(), exp_q.size());
      exp_q.delete();
      obs_q.delete();
    end
  endtask

  initial begin
    cyc   = '0;
    tests = 0;
    fails = 0;
    test_reset();
    test_overflow();
    test_normalized();
    test_deep_and_zero();
    test_back_to_back();
    test_hold();
    test_reset_midflight();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
